// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one borrow flip-flop,
// start/busy/done handshake.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, res_q, res_d, diff_q, diff_d;
   logic br_q, br_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d;
   logic bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;
   logic load, run, last, fin, a0, b0, d, br_nx;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         res_q   <= '0;
         br_q    <= 1'b0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         res_q   <= res_d;
         br_q    <= br_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end
   always_comb begin
      load    = state_q == IDLE && start;
      run     = state_q == RUN;
      last    = cnt_q == CW'(WIDTH - 1);
      state_d = state_q == IDLE ? (start ? RUN : IDLE) :
                state_q == RUN  ? (last ? DONE : RUN) : IDLE;
   end
   // Datapath next state; results are committed on the final bit so they are valid in DONE.
   always_comb begin
      a0      = a_sr_q[0];
      b0      = b_sr_q[0];
      d       = a0 ^ b0 ^ br_q;
      br_nx   = (~a0 & b0) | (~(a0 ^ b0) & br_q);
      fin     = run && last;
      a_sr_d  = load ? a : run ? a_sr_q >> 1 : a_sr_q;
      b_sr_d  = load ? b : run ? b_sr_q >> 1 : b_sr_q;
      br_d    = load ? bin : run ? br_nx : br_q;
      cnt_d   = load ? '0 : run ? cnt_q + CW'(1) : cnt_q;
      res_d   = run ? {d, res_q[WIDTH-1:1]} : res_q;
      a_msb_d = load ? a[WIDTH-1] : a_msb_q;
      b_msb_d = load ? b[WIDTH-1] : b_msb_q;
      diff_d  = fin ? res_d : diff_q;
      bout_d  = fin ? br_nx : bout_q;
      ovf_d   = fin ? (a_msb_q ^ b_msb_q) & (a_msb_q ^ d) : ovf_q;
      zero_d  = fin ? res_d == '0 : zero_q;
   end
   always_comb begin
      busy = state_q != IDLE;
      done = state_q == DONE;
      diff = diff_q;
      bout = bout_q;
      ovf  = ovf_q;
      zero = zero_q;
   end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: vector table, exhaustive sweep and handshake corner cases
// checked through an expected-result queue.
module tb_serial_subtractor;
   typedef struct packed {
      logic [3:0] diff;
      logic       bout;
      logic       ovf;
      logic       zero;
   } exp_t;
   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic       bin;
      exp_t       e;
   } vec_t;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, bin = 1'b0;
   logic [3:0] a = '0, b = '0;
   logic busy, done, bout, ovf, zero;
   logic [3:0] diff;
   int errors = 0, checks = 0, cyc = 0;
   exp_t q[$];
   serial_subtractor #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask
   function automatic exp_t model(input logic [3:0] x, input logic [3:0] y, input logic c);
      logic [4:0] f;
      exp_t r;
      f = {1'b0, x} - {1'b0, y} - {4'b0, c};
      r.diff = f[3:0];
      r.bout = f[4];
      r.ovf  = (x[3] ^ y[3]) & (x[3] ^ f[3]);
      r.zero = f[3:0] == 4'd0;
      return r;
   endfunction
   // Scoreboard: every done pops the oldest expectation
   always @(negedge clk) begin
      if (done) begin
         if (q.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            exp_t e;
            e = q.pop_front();
            chk("diff", diff, e.diff);
            chk("bout", bout, e.bout);
            chk("ovf", ovf, e.ovf);
            chk("zero", zero, e.zero);
         end
      end
   end
   task automatic op(input logic [3:0] x, input logic [3:0] y, input logic c, input exp_t e, output int lat);
      q.push_back(e);
      a = x; b = y; bin = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= 20) chk("done_timeout", 0, 1);
      @(negedge clk);
   endtask
   task automatic chk_zero_outs(input string n);
      chk({n, "_busy"}, busy, 0);
      chk({n, "_done"}, done, 0);
      chk({n, "_diff"}, diff, 0);
      chk({n, "_bout"}, bout, 0);
      chk({n, "_ovf"}, ovf, 0);
      chk({n, "_zero"}, zero, 0);
   endtask
   initial begin
      vec_t tbl[9];
      int lat, n, t[3];
      tbl[0] = '{4'd7, 4'd3, 1'b0, '{4'h4, 1'b0, 1'b0, 1'b0}};
      tbl[1] = '{4'd3, 4'd7, 1'b0, '{4'hC, 1'b1, 1'b0, 1'b0}};
      tbl[2] = '{4'd0, 4'd0, 1'b1, '{4'hF, 1'b1, 1'b0, 1'b0}};
      tbl[3] = '{4'd8, 4'd1, 1'b0, '{4'h7, 1'b0, 1'b1, 1'b0}};
      tbl[4] = '{4'd7, 4'hF, 1'b0, '{4'h8, 1'b1, 1'b1, 1'b0}};
      tbl[5] = '{4'd5, 4'd5, 1'b0, '{4'h0, 1'b0, 1'b0, 1'b1}};
      tbl[6] = '{4'hF, 4'hF, 1'b1, '{4'hF, 1'b1, 1'b0, 1'b0}};
      tbl[7] = '{4'd8, 4'd0, 1'b1, '{4'h7, 1'b0, 1'b1, 1'b0}};
      tbl[8] = '{4'd0, 4'd1, 1'b0, '{4'hF, 1'b1, 1'b0, 1'b0}};
      repeat (2) @(negedge clk);
      chk_zero_outs("reset");
      rst = 1'b0;
      @(negedge clk);
      op(tbl[0].a, tbl[0].b, tbl[0].bin, tbl[0].e, lat);
      chk("latency", lat, 5);
      chk("done_pulse_width", done, 0);
      chk("busy_after_done", busy, 0);
      for (int i = 1; i < 9; i++) op(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].e, lat);
      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            for (int c = 0; c < 2; c++)
               op(4'(x), 4'(y), 1'(c), model(4'(x), 4'(y), 1'(c)), lat);
      // A start pulse while busy must be dropped
      q.push_back(model(4'd7, 4'd3, 1'b0));
      a = 4'd7; b = 4'd3; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_running", busy, 1);
      @(negedge clk);
      a = 4'd9; b = 4'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);
      chk("ignored_start_drained", q.size(), 0);
      // Start held high relaunches every WIDTH+2 cycles
      a = 4'd6; b = 4'd1; bin = 1'b0;
      repeat (3) q.push_back(model(4'd6, 4'd1, 1'b0));
      start = 1'b1;
      n = 0;
      for (int k = 0; k < 40 && n < 3; k++) begin
         @(negedge clk);
         if (done) begin
            t[n] = cyc;
            n++;
            if (n == 3) start = 1'b0;
         end
      end
      start = 1'b0;
      chk("held_start_ops", n, 3);
      chk("interval_1", t[1] - t[0], 6);
      chk("interval_2", t[2] - t[1], 6);
      repeat (10) @(negedge clk);
      chk("held_start_stopped", busy, 0);
      // Reset during RUN abandons the op and clears the held result
      a = 4'd7; b = 4'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_zero_outs("mid_reset");
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("no_done_after_reset", q.size(), 0);
      op(4'd6, 4'd1, 1'b0, '{4'h5, 1'b0, 1'b0, 1'b0}, lat);
      chk("final_diff_held", diff, 5);
      chk("queue_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
